// File: rtl/tl_pkg.sv
// Shared definitions for the traffic light controller: light encodings, car count width
// and the sensor debounce state encoding.
package tl_pkg;

    localparam logic [1:0] LIGHT_OFF    = 2'b00;
    localparam logic [1:0] LIGHT_RED    = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_GREEN  = 2'b11;

    localparam int unsigned CAR_CNT_W = 8;

    typedef logic [1:0] db_state_t;

    localparam db_state_t DB_LOW      = 2'd0;
    localparam db_state_t DB_RISE_CHK = 2'd1;
    localparam db_state_t DB_HIGH     = 2'd2;
    localparam db_state_t DB_FALL_CHK = 2'd3;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus debounce FSM for one raw loop sensor; emits a single-cycle
// event when a rising level has been stable for DEBOUNCE_CYCLES synchronised samples.
module sensor_debounce
    import tl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);

    localparam logic [3:0] RunLast = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q, sync2_q;
    db_state_t  state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       evt_q, evt_d;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        evt_d   = 1'b0;
        case (state_q)
            DB_LOW: begin
                if (sync2_q) begin
                    state_d = DB_RISE_CHK;
                    run_d   = 4'd1;
                end
            end
            DB_RISE_CHK: begin
                if (!sync2_q) begin
                    state_d = DB_LOW;
                end else if (run_q >= RunLast) begin
                    state_d = DB_HIGH;
                    evt_d   = 1'b1;
                end else begin
                    run_d = run_q + 4'd1;
                end
            end
            DB_HIGH: begin
                if (!sync2_q) begin
                    state_d = DB_FALL_CHK;
                    run_d   = 4'd1;
                end
            end
            DB_FALL_CHK: begin
                if (sync2_q) begin
                    state_d = DB_HIGH;
                end else if (run_q >= RunLast) begin
                    state_d = DB_LOW;
                end else begin
                    run_d = run_q + 4'd1;
                end
            end
            default: state_d = DB_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= DB_LOW;
            run_q   <= 4'd0;
            evt_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            state_q <= state_d;
            run_q   <= run_d;
            evt_q   <= evt_d;
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/sr_car_counter.sv
// Secondary-road queue counter: debounced arrival/departure events drive a saturating
// up/down count, with departures only honoured while the secondary light is yellow/green.
module sr_car_counter
    import tl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_MAX         = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arr_sensor,
    input  logic                 dep_sensor,
    input  logic [1:0]           SR_ctl,
    output logic [CAR_CNT_W-1:0] MR_cars,
    output logic                 cnt_full,
    output logic                 cnt_err
);

    localparam logic [CAR_CNT_W-1:0] CntMax = CAR_CNT_W'(CNT_MAX);

    logic                 arr_evt, dep_evt, dep_ok;
    logic [CAR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 full_q, full_d;
    logic                 err_q, err_d;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_arr_debounce (
        .clk(clk),
        .rst(rst),
        .raw(arr_sensor),
        .evt(arr_evt)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_dep_debounce (
        .clk(clk),
        .rst(rst),
        .raw(dep_sensor),
        .evt(dep_evt)
    );

    assign dep_ok = dep_evt & ((SR_ctl == LIGHT_GREEN) | (SR_ctl == LIGHT_YELLOW));

    always_comb begin
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (arr_evt && dep_ok) begin
            cnt_d = cnt_q;
        end else if (arr_evt) begin
            if (cnt_q < CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end
            // A departure seen on red/off alongside an arrival is still flagged.
            err_d = dep_evt;
        end else if (dep_ok) begin
            if (cnt_q > '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (dep_evt) begin
            err_d = 1'b1;
        end
        full_d = (cnt_d == CntMax);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
            err_q  <= err_d;
        end
    end

    assign MR_cars  = cnt_q;
    assign cnt_full = full_q;
    assign cnt_err  = err_q;

endmodule

// File: tb/tb_sr_car_counter.sv
// Scenario bench for sr_car_counter: expected counter states are queued when sensor
// stimulus is driven and compared every cycle by a monitor against the queued schedule.
`timescale 1ns/1ps
module tb_sr_car_counter;

    typedef struct {
        int unsigned due;
        logic [7:0]  cnt;
        logic        full;
        logic        err;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arr_sensor = 1'b0;
    logic       dep_sensor = 1'b0;
    logic [1:0] SR_ctl = 2'b00;
    logic [7:0] MR_cars;
    logic       cnt_full;
    logic       cnt_err;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    sb_t         sb[$];
    sb_t         mon_e;
    bit          mon_en = 1'b0;
    int          model_cnt = 0;
    logic [7:0]  cur_cnt = 8'd0;
    logic        cur_full = 1'b0;
    logic        exp_err;

    sr_car_counter dut (
        .clk(clk),
        .rst(rst),
        .arr_sensor(arr_sensor),
        .dep_sensor(dep_sensor),
        .SR_ctl(SR_ctl),
        .MR_cars(MR_cars),
        .cnt_full(cnt_full),
        .cnt_err(cnt_err)
    );

    always #0.5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle the outputs must match the last scheduled state; cnt_err only on a due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_err = 1'b0;
            if (sb.size() != 0 && sb[0].due == cyc) begin
                mon_e    = sb.pop_front();
                cur_cnt  = mon_e.cnt;
                cur_full = mon_e.full;
                exp_err  = mon_e.err;
            end
            checks++;
            if (MR_cars !== cur_cnt || cnt_full !== cur_full || cnt_err !== exp_err) begin
                errors++;
                $display("FAIL monitor cyc=%0d: got cnt=%0d full=%b err=%b, want cnt=%0d full=%b err=%b",
                         cyc, MR_cars, cnt_full, cnt_err, cur_cnt, cur_full, exp_err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Predict the counter effect of events firing together and schedule it.
    task automatic push_expect(input int unsigned due, input bit a, input bit d,
                               input logic [1:0] sr);
        sb_t e;
        bit  ok;
        ok    = d && (sr == 2'b11 || sr == 2'b10);
        e.due = due;
        e.err = 1'b0;
        if (a && ok) begin
        end else if (a) begin
            if (model_cnt < 255) model_cnt++;
            e.err = d;
        end else if (ok) begin
            if (model_cnt > 0) model_cnt--;
            else e.err = 1'b1;
        end else if (d) begin
            e.err = 1'b1;
        end
        e.cnt  = 8'(model_cnt);
        e.full = (model_cnt == 255);
        sb.push_back(e);
    endtask

    // Raise the chosen sensors for hi samples, then drop them for lo samples.
    task automatic pulse(input bit a, input bit d, input logic [1:0] sr,
                         input int hi, input int lo);
        int unsigned c;
        @(posedge clk);
        #0.1;
        c          = cyc;
        SR_ctl     = sr;
        arr_sensor = a;
        dep_sensor = d;
        push_expect(c + 7, a, d, sr);
        repeat (hi) @(posedge clk);
        #0.1;
        arr_sensor = 1'b0;
        dep_sensor = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events still pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic reset_dut();
        mon_en = 1'b0;
        @(posedge clk);
        #0.1;
        rst        = 1'b1;
        arr_sensor = 1'b0;
        dep_sensor = 1'b0;
        repeat (2) @(posedge clk);
        #0.1;
        rst       = 1'b0;
        sb.delete();
        model_cnt = 0;
        cur_cnt   = 8'd0;
        cur_full  = 1'b0;
        mon_en    = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (MR_cars !== 8'd0 || cnt_full !== 1'b0 || cnt_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got cnt=%0d full=%b err=%b, want 0 0 0",
                         MR_cars, cnt_full, cnt_err);
            end
        end
        @(posedge clk);
        #0.1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (MR_cars !== 8'd0 || cnt_full !== 1'b0 || cnt_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_release: got cnt=%0d full=%b err=%b, want 0 0 0",
                         MR_cars, cnt_full, cnt_err);
            end
        end
        model_cnt = 0;
        cur_cnt   = 8'd0;
        cur_full  = 1'b0;
        mon_en    = 1'b1;
    endtask

    task automatic test_arrival_latency();
        int unsigned c;
        @(posedge clk);
        #0.1;
        c          = cyc;
        arr_sensor = 1'b1;
        push_expect(c + 7, 1'b1, 1'b0, SR_ctl);
        while (cyc != c + 6) @(negedge clk);
        checks++;
        if (MR_cars !== 8'd0) begin
            errors++;
            $display("FAIL latency_early: got cnt=%0d one edge early, want 0", MR_cars);
        end
        @(negedge clk);
        checks++;
        if (MR_cars !== 8'd1) begin
            errors++;
            $display("FAIL latency_on_time: got cnt=%0d at edge k+6, want 1", MR_cars);
        end
        while (cyc != c + 10) @(negedge clk);
        arr_sensor = 1'b0;
        repeat (10) @(posedge clk);
        // Three high samples are one short of acceptance.
        #0.1;
        arr_sensor = 1'b1;
        repeat (3) @(posedge clk);
        #0.1;
        arr_sensor = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        checks++;
        if (MR_cars !== 8'd1) begin
            errors++;
            $display("FAIL glitch: got cnt=%0d, want 1", MR_cars);
        end
    endtask

    task automatic test_departures();
        reset_dut();
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 2'b01, 6, 6);
        for (int i = 0; i < 2; i++) pulse(1'b0, 1'b1, 2'b11, 6, 6);
        wait_drain();
        checks++;
        if (MR_cars !== 8'd3) begin
            errors++;
            $display("FAIL depart_green: got cnt=%0d, want 3", MR_cars);
        end
        pulse(1'b0, 1'b1, 2'b01, 6, 6);
        wait_drain();
        checks++;
        if (MR_cars !== 8'd3 || cnt_err !== 1'b0) begin
            errors++;
            $display("FAIL depart_red: got cnt=%0d err=%b, want 3 0", MR_cars, cnt_err);
        end
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int i = 0; i < 255; i++) pulse(1'b1, 1'b0, 2'b01, 6, 6);
        wait_drain();
        checks++;
        if (MR_cars !== 8'd255 || cnt_full !== 1'b1) begin
            errors++;
            $display("FAIL fill: got cnt=%0d full=%b, want 255 1", MR_cars, cnt_full);
        end
        pulse(1'b1, 1'b0, 2'b01, 6, 6);
        wait_drain();
        checks++;
        if (MR_cars !== 8'd255 || cnt_full !== 1'b1 || cnt_err !== 1'b0) begin
            errors++;
            $display("FAIL saturate: got cnt=%0d full=%b err=%b, want 255 1 0",
                     MR_cars, cnt_full, cnt_err);
        end
        pulse(1'b0, 1'b1, 2'b11, 6, 6);
        wait_drain();
        checks++;
        if (MR_cars !== 8'd254 || cnt_full !== 1'b0) begin
            errors++;
            $display("FAIL leave_full: got cnt=%0d full=%b, want 254 0", MR_cars, cnt_full);
        end
    endtask

    task automatic test_underflow_and_simul();
        reset_dut();
        pulse(1'b0, 1'b1, 2'b11, 6, 6);
        wait_drain();
        checks++;
        if (MR_cars !== 8'd0) begin
            errors++;
            $display("FAIL underflow: got cnt=%0d, want 0", MR_cars);
        end
        for (int i = 0; i < 7; i++) pulse(1'b1, 1'b0, 2'b10, 6, 6);
        pulse(1'b1, 1'b1, 2'b10, 6, 6);
        wait_drain();
        checks++;
        if (MR_cars !== 8'd7 || cnt_err !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous: got cnt=%0d err=%b, want 7 0", MR_cars, cnt_err);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int unsigned c;
        reset_dut();
        for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0, 2'b01, 6, 6);
        wait_drain();
        checks++;
        if (MR_cars !== 8'd12) begin
            errors++;
            $display("FAIL preload: got cnt=%0d, want 12", MR_cars);
        end
        @(posedge clk);
        #0.1;
        arr_sensor = 1'b1;
        repeat (3) @(posedge clk);
        #0.1;
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #0.1;
        rst       = 1'b0;
        c         = cyc;
        sb.delete();
        model_cnt = 0;
        cur_cnt   = 8'd0;
        cur_full  = 1'b0;
        push_expect(c + 7, 1'b1, 1'b0, SR_ctl);
        @(negedge clk);
        checks++;
        if (MR_cars !== 8'd0 || cnt_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got cnt=%0d err=%b, want 0 0", MR_cars, cnt_err);
        end
        mon_en = 1'b1;
        repeat (10) @(posedge clk);
        #0.1;
        arr_sensor = 1'b0;
        wait_drain();
        checks++;
        if (MR_cars !== 8'd1) begin
            errors++;
            $display("FAIL held_through_reset: got cnt=%0d, want 1", MR_cars);
        end
    endtask

    initial begin
        test_reset();
        test_arrival_latency();
        test_departures();
        test_saturation();
        test_underflow_and_simul();
        test_reset_mid_debounce();
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
